// File: rtl/demux4_buffered_pkg.sv
// rtl/demux4_buffered_pkg.sv - shared constants and helpers for the buffered 1-to-4 demultiplexer
package demux4_buffered_pkg;

  // Default word and counter widths
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 8;

  // Number of consumer channels
  localparam int NUM_CH = 4;

  // Selector codes for each destination channel
  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

  // Low bit offset of channel ch inside a packed per-channel bus of width w per channel
  function automatic int slot_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/demux4_slot.sv
// rtl/demux4_slot.sv - single-entry output slot with valid/ready handshake and transfer counter
module demux4_slot
  import demux4_buffered_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  input  logic              cnt_clear,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free,
  output logic [CNT_W-1:0]  count
);

  // The slot can take a new word if it is empty or its word leaves this cycle
  assign free = !valid || drain;

  // Valid bit: a load always wins, so drain-and-refill keeps the slot occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // Data register: only written on load, so it holds its last value after a drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

  // Accepted-word counter: wraps naturally, clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (cnt_clear) begin
      count <= '0;
    end else if (load) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/demux4_buffered.sv
// rtl/demux4_buffered.sv - routes one producer stream into four independently stalled buffered channels
module demux4_buffered
  import demux4_buffered_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_sel,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic                     cnt_clear,
  output logic [NUM_CH*CNT_W-1:0]  xfer_count
);

  logic [NUM_CH-1:0] sel_hot;
  logic [NUM_CH-1:0] slot_free;
  logic [NUM_CH-1:0] slot_load;
  logic              in_fire;

  // One-hot decode of the destination selector
  always_comb begin
    sel_hot = '0;
    case (in_sel)
      CH0: sel_hot[0] = 1'b1;
      CH1: sel_hot[1] = 1'b1;
      CH2: sel_hot[2] = 1'b1;
      CH3: sel_hot[3] = 1'b1;
    endcase
  end

  // Ready follows the addressed slot only; a stalled slot never blocks other channels
  assign in_ready  = slot_free[in_sel];
  assign in_fire   = in_valid && in_ready;
  assign slot_load = sel_hot & {NUM_CH{in_fire}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux4_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (slot_load[i]),
      .load_data (in_data),
      .drain     (out_ready[i]),
      .cnt_clear (cnt_clear),
      .valid     (out_valid[i]),
      .data      (out_data[slot_lo(i, DATA_W) +: DATA_W]),
      .free      (slot_free[i]),
      .count     (xfer_count[slot_lo(i, CNT_W) +: CNT_W])
    );
  end

endmodule
